// File: rtl/vecmac_lane_accumulator.sv
// Reduction half of the int8 vector MAC: sums four 16-bit lane products per beat,
// accumulates cfg_len beats per vector and queues finished dot products in a 2-entry FIFO.
module vecmac_lane_accumulator #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [63:0]      in_product,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy,
    output logic             err_drop
);

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             s1_valid_q, s1_valid_d;
    logic [17:0]      s1_sum_q, s1_sum_d;
    logic             s1_first_q, s1_first_d;
    logic             s1_last_q, s1_last_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s2_last_q, s2_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] mem_data_q [2];
    logic [ACC_W-1:0] mem_data_d [2];
    logic             mem_ovf_q [2];
    logic             mem_ovf_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             err_drop_q, err_drop_d;

    logic             beat_first_s;
    logic             beat_last_s;
    logic [LEN_W-1:0] eff_len_s;
    logic [17:0]      lane_sum_s;
    logic [ACC_W:0]   acc_sum_s;
    logic             push_s;
    logic             pop_s;
    logic             push_ok_s;

    assign lane_sum_s = 18'(in_product[15:0])  + 18'(in_product[31:16])
                      + 18'(in_product[47:32]) + 18'(in_product[63:48]);

    // Vector framing: the length is captured only on a first beat so mid-vector cfg_len edits are ignored
    always_comb begin
        beat_first_s = (cnt_q == '0);
        if (beat_first_s) begin
            eff_len_s = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        end else begin
            eff_len_s = len_q;
        end
        beat_last_s = (cnt_q == (eff_len_s - LEN_W'(1)));
    end

    // Pipeline next state: S1 registers the lane sum and flags, S2 accumulates
    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        acc_sum_s  = {1'b0, acc_q} + (ACC_W+1)'(s1_sum_q);
        if (clear) begin
            cnt_d      = '0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s2_last_d  = 1'b0;
            acc_d      = '0;
            ovf_d      = 1'b0;
        end else begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d   = lane_sum_s;
                s1_first_d = beat_first_s;
                s1_last_d  = beat_last_s;
                if (beat_first_s) begin
                    len_d = eff_len_s;
                end else begin
                    len_d = len_q;
                end
                cnt_d = beat_last_s ? '0 : (cnt_q + LEN_W'(1));
            end else begin
                cnt_d = cnt_q;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_last_d = s1_last_q;
                if (s1_first_q) begin
                    acc_d = ACC_W'(s1_sum_q);
                    ovf_d = 1'b0;
                end else begin
                    acc_d = acc_sum_s[ACC_W-1:0];
                    ovf_d = ovf_q | acc_sum_s[ACC_W];
                end
            end else begin
                s2_last_d = s2_last_q;
            end
        end
    end

    // Result FIFO: a push into a full buffer survives only when the head is popped on the same edge
    always_comb begin
        mem_data_d = mem_data_q;
        mem_ovf_d  = mem_ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_drop_d = err_drop_q;
        push_s     = s2_valid_q & s2_last_q & ~clear;
        pop_s      = (count_q != 2'd0) & res_ready;
        push_ok_s  = push_s & ((count_q != 2'd2) | pop_s);
        if (push_ok_s) begin
            mem_data_d[wr_ptr_q] = acc_q;
            mem_ovf_d[wr_ptr_q]  = ovf_q;
            wr_ptr_d             = ~wr_ptr_q;
        end else if (push_s) begin
            err_drop_d = 1'b1;
        end else begin
            err_drop_d = err_drop_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            len_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_sum_q      <= '0;
            s1_first_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_last_q     <= 1'b0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            mem_data_q[0] <= '0;
            mem_data_q[1] <= '0;
            mem_ovf_q[0]  <= 1'b0;
            mem_ovf_q[1]  <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            err_drop_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            s1_valid_q    <= s1_valid_d;
            s1_sum_q      <= s1_sum_d;
            s1_first_q    <= s1_first_d;
            s1_last_q     <= s1_last_d;
            s2_valid_q    <= s2_valid_d;
            s2_last_q     <= s2_last_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            mem_data_q[0] <= mem_data_d[0];
            mem_data_q[1] <= mem_data_d[1];
            mem_ovf_q[0]  <= mem_ovf_d[0];
            mem_ovf_q[1]  <= mem_ovf_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            err_drop_q    <= err_drop_d;
        end
    end

    assign res_valid = (count_q != 2'd0);
    assign res_data  = mem_data_q[rd_ptr_q];
    assign res_ovf   = mem_ovf_q[rd_ptr_q];
    assign busy      = (cnt_q != '0) | s1_valid_q | s2_valid_q;
    assign err_drop  = err_drop_q;

endmodule
